// File: rtl/register_write_sequencer_if.sv
// Register-write port from the playback engine toward the channel register file.
//   out_valid : write pending (master -> slave)
//   out_ready : slave accepts the pending write (slave -> master)
//   out_ch    : target channel
//   out_reg   : target register within the channel
//   out_data  : register write data
interface register_write_sequencer_if #(
  parameter int CH_W   = 2,
  parameter int REG_W  = 3,
  parameter int DATA_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_ch;
  logic [REG_W-1:0]  out_reg;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, out_ch, out_reg, out_data, input out_ready);
  modport slave  (input out_valid, out_ch, out_reg, out_data, output out_ready);
endinterface

// File: rtl/register_write_sequencer.sv
// Programmable APU playback engine. Steps through an event RAM of
// {delay, ch, reg, data} entries on the tempo tick and emits register writes
// over a valid/ready port. Supports chords (zero-delay entries), loop regions,
// abort and a completion pulse.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   tick                 : one-cycle tempo strobe
//   prog_we/addr/data    : event RAM write port (accepted in any state)
//   start, stop          : begin playback at index 0 / abort playback
//   loop_en, loop_start  : wrap to loop_start after end_idx instead of finishing
//   end_idx              : index of the last entry
//   wr                   : register-write handshake port (master side)
//   busy, step_idx, done : playback active, current entry index, completion pulse
module register_write_sequencer #(
  parameter int NUM_CH  = 4,
  parameter int DEPTH   = 128,
  parameter int REG_W   = 3,
  parameter int DATA_W  = 8,
  parameter int DELAY_W = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int IDX_W   = $clog2(DEPTH),
  localparam int ENTRY_W = DELAY_W + CH_W + REG_W + DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      prog_we,
  input  logic [IDX_W-1:0]          prog_addr,
  input  logic [ENTRY_W-1:0]        prog_data,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      loop_en,
  input  logic [IDX_W-1:0]          loop_start,
  input  logic [IDX_W-1:0]          end_idx,
  register_write_sequencer_if.master wr,
  output logic                      busy,
  output logic [IDX_W-1:0]          step_idx,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

  state_t               state, state_d;
  logic [ENTRY_W-1:0]   mem [DEPTH];
  logic [ENTRY_W-1:0]   entry_p1;
  logic [IDX_W-1:0]     step_d;
  logic [DELAY_W-1:0]   cnt, cnt_d;
  logic                 done_d;
  logic                 advance;

  logic [DELAY_W-1:0]   e_delay;
  logic [CH_W-1:0]      e_ch;
  logic [REG_W-1:0]     e_reg;
  logic [DATA_W-1:0]    e_data;
  logic                 ch_ok;
  logic                 issue_vld;
  logic                 hs;

  assign e_delay = entry_p1[ENTRY_W-1 -: DELAY_W];
  assign e_ch    = entry_p1[DATA_W+REG_W +: CH_W];
  assign e_reg   = entry_p1[DATA_W +: REG_W];
  assign e_data  = entry_p1[DATA_W-1:0];

  // Entries addressing a channel that does not exist are skipped silently:
  // no valid, and the handshake completes on its own.
  assign ch_ok     = int'(e_ch) < NUM_CH;
  assign issue_vld = (state == S_ISSUE) && ch_ok;
  assign hs        = (state == S_ISSUE) && (!ch_ok || wr.out_ready);

  // ---- stage p0 -> p1: event RAM write port and synchronous read ----
  // Read-before-write: a write to the fetched index in the FETCH cycle
  // leaves the old entry in entry_p1.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    if (state == S_FETCH) entry_p1 <= mem[step_idx];
  end

  always_comb begin
    state_d = state;
    step_d  = step_idx;
    cnt_d   = cnt;
    done_d  = 1'b0;
    advance = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          step_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_ISSUE;
      S_ISSUE: begin
        if (hs) begin
          if (e_delay == '0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = e_delay;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (tick) begin
          if (cnt == DELAY_W'(1)) advance = 1'b1;
          else                    cnt_d   = cnt - DELAY_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Loop controls are sampled here, so they may change during playback.
    if (advance) begin
      cnt_d = '0;
      if (step_idx != end_idx) begin
        step_d  = step_idx + IDX_W'(1);
        state_d = S_FETCH;
      end else if (loop_en) begin
        step_d  = loop_start;
        state_d = S_FETCH;
      end else begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    // Abort wins over start and over any completion in the same cycle.
    if (stop) begin
      state_d = S_IDLE;
      step_d  = step_idx;
      cnt_d   = '0;
      done_d  = 1'b0;
    end
  end

  // ---- stage p1 -> p2: control registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      step_idx <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      step_idx <= step_d;
      cnt      <= cnt_d;
      done     <= done_d;
    end
  end

  assign busy         = (state != S_IDLE);
  assign wr.out_valid = issue_vld;
  assign wr.out_ch    = issue_vld ? e_ch   : '0;
  assign wr.out_reg   = issue_vld ? e_reg  : '0;
  assign wr.out_data  = issue_vld ? e_data : '0;

endmodule
